// File: rtl/memory_port_arbiter.sv
// Two-requester round-robin arbiter for the single hart-to-memory channel.
// One transaction in flight; responses route to the owner; timeouts drain the late reply.
module memory_port_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic [31:0] req0_address,
  input  logic [31:0] req1_address,
  input  logic        req0_write,
  input  logic        req1_write,
  input  logic [31:0] req0_write_data,
  input  logic [31:0] req1_write_data,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  output logic        rsp0_error,
  output logic        rsp1_error,
  output logic [31:0] rsp0_read_data,
  output logic [31:0] rsp1_read_data,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic        hart_to_memory_controller_valid,
  output logic [31:0] hart_to_memory_controller_address,
  output logic        hart_to_memory_controller_write,
  output logic [31:0] hart_to_memory_controller_write_data,
  input  logic        hart_to_memory_controller_ready,
  input  logic        memory_controller_to_hart_valid,
  input  logic        memory_controller_to_hart_error,
  input  logic [31:0] memory_controller_to_hart_read_data,
  output logic        memory_controller_to_hart_ready,
  output logic        busy,
  output logic        timeout_pulse,
  output logic [1:0]  o_dbg_state
);

  // A zero TIMEOUT still needs a legal one-bit counter; it simply never fires.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_grant;
  logic            r_last;
  logic            r_drain;
  logic            r_timeout_pulse;
  logic [CW-1:0]   r_cnt;

  logic            w_req_valid;
  logic            w_rsp_ready;
  logic            w_mem_valid;
  logic            w_accept;
  logic            w_timed_out;
  logic            w_rsp_done;
  logic            w_to_done;
  logic            w_any_req;
  logic            w_arb_grant;

  assign w_mem_valid = memory_controller_to_hart_valid;
  assign w_req_valid = r_grant ? req1_valid : req0_valid;
  assign w_rsp_ready = r_grant ? rsp1_ready : rsp0_ready;
  assign w_any_req   = req0_valid || req1_valid;
  assign w_arb_grant = (req0_valid && req1_valid) ? ~r_last : req1_valid;
  assign w_accept    = (r_state == S_REQ) && w_req_valid &&
                       hart_to_memory_controller_ready;
  // A response arriving on the threshold cycle wins over the timeout.
  assign w_timed_out = (TIMEOUT != 0) && (r_state == S_WAIT) &&
                       (r_cnt == CW'(TIMEOUT)) && !w_mem_valid;
  assign w_rsp_done  = (r_state == S_WAIT) && w_mem_valid && w_rsp_ready;
  assign w_to_done   = w_timed_out && w_rsp_ready;

  always_ff @(posedge clock) begin
    if (!clear) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (!r_drain && w_any_req) w_next = S_REQ;
      S_REQ: begin
        if (!w_req_valid)  w_next = S_IDLE;
        else if (w_accept) w_next = S_WAIT;
      end
      S_WAIT: if (w_rsp_done || w_to_done) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      r_grant         <= 1'b0;
      r_last          <= 1'b1;
      r_drain         <= 1'b0;
      r_cnt           <= '0;
      r_timeout_pulse <= 1'b0;
    end else begin
      r_timeout_pulse <= w_to_done;
      if (r_state == S_IDLE && !r_drain && w_any_req) r_grant <= w_arb_grant;
      if (w_rsp_done || w_to_done) r_last <= r_grant;
      if (w_to_done)                   r_drain <= 1'b1;
      else if (r_drain && w_mem_valid) r_drain <= 1'b0;
      if (w_accept)
        r_cnt <= '0;
      else if (r_state == S_WAIT && r_cnt != CW'(TIMEOUT))
        r_cnt <= r_cnt + CW'(1);
    end
  end

  always_comb begin
    hart_to_memory_controller_valid      = 1'b0;
    hart_to_memory_controller_address    = '0;
    hart_to_memory_controller_write      = 1'b0;
    hart_to_memory_controller_write_data = '0;
    req0_ready     = 1'b0;
    req1_ready     = 1'b0;
    rsp0_valid     = 1'b0;
    rsp1_valid     = 1'b0;
    rsp0_error     = 1'b0;
    rsp1_error     = 1'b0;
    rsp0_read_data = memory_controller_to_hart_read_data;
    rsp1_read_data = memory_controller_to_hart_read_data;
    // Drain swallows exactly one late response; it is only ever set in IDLE.
    memory_controller_to_hart_ready = r_drain;
    case (r_state)
      S_REQ: begin
        hart_to_memory_controller_valid      = w_req_valid;
        hart_to_memory_controller_address    = r_grant ? req1_address : req0_address;
        hart_to_memory_controller_write      = r_grant ? req1_write : req0_write;
        hart_to_memory_controller_write_data = r_grant ? req1_write_data : req0_write_data;
        req0_ready = !r_grant && hart_to_memory_controller_ready;
        req1_ready =  r_grant && hart_to_memory_controller_ready;
      end
      S_WAIT: begin
        memory_controller_to_hart_ready = w_rsp_ready;
        if (!r_grant) begin
          rsp0_valid = w_mem_valid || w_timed_out;
          rsp0_error = w_timed_out || memory_controller_to_hart_error;
          if (w_timed_out) rsp0_read_data = '0;
        end else begin
          rsp1_valid = w_mem_valid || w_timed_out;
          rsp1_error = w_timed_out || memory_controller_to_hart_error;
          if (w_timed_out) rsp1_read_data = '0;
        end
      end
      default: ;
    endcase
  end

  assign busy          = (r_state != S_IDLE) || r_drain;
  assign timeout_pulse = r_timeout_pulse;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed + randomized bench for memory_port_arbiter against a transaction-level
// round-robin model; inputs change on the falling edge, outputs are checked 1 ns later.
module tb_memory_port_arbiter;
  localparam int TIMEOUT = 4;

  logic        clock = 1'b0;
  logic        clear;
  logic [1:0]  req_v, req_w, rsp_rdy;
  logic [31:0] req_a [2];
  logic [31:0] req_d [2];
  logic        q0_rdy, q1_rdy, s0_v, s1_v, s0_e, s1_e;
  logic [31:0] s0_d, s1_d;
  logic        h_v, h_w, h_rdy, m_v, m_e, m_rdy, busy, tpulse;
  logic [31:0] h_a, h_d, m_d;
  logic [1:0]  dbg_state;
  logic [1:0]  req_rdy, rsp_v, rsp_e;
  logic [31:0] rsp_dd [2];

  assign req_rdy   = {q1_rdy, q0_rdy};
  assign rsp_v     = {s1_v, s0_v};
  assign rsp_e     = {s1_e, s0_e};
  assign rsp_dd[0] = s0_d;
  assign rsp_dd[1] = s1_d;

  always #5 clock = ~clock;

  memory_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .clear(clear),
    .req0_valid(req_v[0]), .req1_valid(req_v[1]),
    .req0_address(req_a[0]), .req1_address(req_a[1]),
    .req0_write(req_w[0]), .req1_write(req_w[1]),
    .req0_write_data(req_d[0]), .req1_write_data(req_d[1]),
    .req0_ready(q0_rdy), .req1_ready(q1_rdy),
    .rsp0_valid(s0_v), .rsp1_valid(s1_v),
    .rsp0_error(s0_e), .rsp1_error(s1_e),
    .rsp0_read_data(s0_d), .rsp1_read_data(s1_d),
    .rsp0_ready(rsp_rdy[0]), .rsp1_ready(rsp_rdy[1]),
    .hart_to_memory_controller_valid(h_v),
    .hart_to_memory_controller_address(h_a),
    .hart_to_memory_controller_write(h_w),
    .hart_to_memory_controller_write_data(h_d),
    .hart_to_memory_controller_ready(h_rdy),
    .memory_controller_to_hart_valid(m_v),
    .memory_controller_to_hart_error(m_e),
    .memory_controller_to_hart_read_data(m_d),
    .memory_controller_to_hart_ready(m_rdy),
    .busy(busy), .timeout_pulse(tpulse), .o_dbg_state(dbg_state)
  );

  int          n_vec = 0;
  int          n_err = 0;
  bit          model_last;
  bit          pend_v [2];
  logic        pend_w [2];
  logic [31:0] pend_a [2];
  logic [31:0] pend_d [2];
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_req(input int p);
    pend_v[p] = 1'b1;
    pend_a[p] = $urandom;
    pend_w[p] = 1'($urandom_range(0, 1));
    pend_d[p] = $urandom;
  endtask

  task automatic refill();
    for (int p = 0; p < 2; p++)
      if (!pend_v[p] && $urandom_range(0, 1) == 1) new_req(p);
    if (!pend_v[0] && !pend_v[1]) new_req($urandom_range(0, 1));
  endtask

  task automatic drive_reqs();
    for (int p = 0; p < 2; p++) begin
      req_v[p] = pend_v[p];
      req_a[p] = pend_a[p];
      req_w[p] = pend_w[p];
      req_d[p] = pend_d[p];
    end
  endtask

  // One full transaction from IDLE: grant per round-robin rule, accept after
  // rdy_dly stalls, response after rsp_dly, owner consumes rr_dly later.
  task automatic do_txn(input int rdy_dly, input int rsp_dly, input int rr_dly,
                        input bit err, input logic [31:0] rd);
    int g;
    logic [31:0] rdata;
    g = (pend_v[0] && pend_v[1]) ? (model_last ? 0 : 1) : (pend_v[1] ? 1 : 0);
    exp_q.push_back(pend_a[g]);
    @(negedge clock);
    drive_reqs(); h_rdy = 1'b0; m_v = 1'b0; rsp_rdy = 2'b00;
    #1;
    chk("arb_latency_valid", h_v, 0);
    chk("idle_busy", busy, 0);
    chk("idle_mem_ready", m_rdy, 0);
    chk("idle_req_ready", req_rdy, 0);
    for (int i = 0; i <= rdy_dly; i++) begin
      @(negedge clock);
      h_rdy = (i == rdy_dly);
      #1;
      chk("req_valid", h_v, 1);
      chk("req_addr", h_a, pend_a[g]);
      chk("req_write", h_w, pend_w[g]);
      chk("req_wdata", h_d, pend_d[g]);
      chk("req_ready", req_rdy, (i == rdy_dly) ? (32'd1 << g) : 32'd0);
      if (i == rdy_dly) chk("sb_accept_addr", h_a, exp_q.pop_front());
    end
    pend_v[g] = 1'b0;
    for (int j = 0; j <= rsp_dly + rr_dly; j++) begin
      @(negedge clock);
      h_rdy = 1'b0; drive_reqs();
      rdata = (rd != 0) ? rd : $urandom;
      m_v = (j >= rsp_dly); m_e = err; m_d = rdata;
      rsp_rdy[g]     = (j == rsp_dly + rr_dly);
      rsp_rdy[1 - g] = 1'($urandom_range(0, 1));
      #1;
      chk("rsp_valid_owner", rsp_v[g], (j >= rsp_dly));
      chk("rsp_valid_other", rsp_v[1 - g], 0);
      chk("rsp_data_owner", rsp_dd[g], rdata);
      chk("rsp_data_other", rsp_dd[1 - g], rdata);
      if (j >= rsp_dly) chk("rsp_error", rsp_e[g], err);
      chk("wait_mem_ready", m_rdy, (j == rsp_dly + rr_dly));
      chk("wait_busy", busy, 1);
      chk("wait_req_ready", req_rdy, 0);
      chk("wait_down_valid", h_v, 0);
    end
    model_last = (g == 1);
  endtask

  initial begin
    clear = 1'b0; req_v = '0; req_w = '0; rsp_rdy = '0;
    req_a[0] = '0; req_a[1] = '0; req_d[0] = '0; req_d[1] = '0;
    h_rdy = 1'b0; m_v = 1'b0; m_e = 1'b0; m_d = '0;
    pend_v[0] = 1'b0; pend_v[1] = 1'b0;
    model_last = 1'b1;

    // Reset values
    repeat (2) @(negedge clock);
    #1;
    chk("rst_req_ready", req_rdy, 0);
    chk("rst_rsp_valid", rsp_v, 0);
    chk("rst_rsp_error", rsp_e, 0);
    chk("rst_down_valid", h_v, 0);
    chk("rst_down_write", h_w, 0);
    chk("rst_mem_ready", m_rdy, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_pulse", tpulse, 0);
    clear = 1'b1;

    // Single load on port 1
    new_req(1); pend_a[1] = 32'h100; pend_w[1] = 1'b0;
    do_txn(0, 0, 0, 1'b0, 32'hDEADBEEF);

    // Contention from reset: grants alternate starting with port 0
    @(negedge clock); clear = 1'b0; drive_reqs(); m_v = 1'b0;
    @(negedge clock); clear = 1'b1;
    model_last = 1'b1;
    new_req(0); new_req(1);
    for (int t = 0; t < 4; t++) begin
      do_txn($urandom_range(0, 1), $urandom_range(0, 2), 0, 1'b0, 32'd0);
      for (int p = 0; p < 2; p++) if (!pend_v[p]) new_req(p);
    end
    pend_v[0] = 1'b0; pend_v[1] = 1'b0;
    @(negedge clock); clear = 1'b0; drive_reqs(); m_v = 1'b0; rsp_rdy = '0;
    @(negedge clock); clear = 1'b1;
    model_last = 1'b1;

    // Store pass-through with a 3-cycle downstream stall
    pend_v[0] = 1'b1; pend_a[0] = 32'h44; pend_w[0] = 1'b1; pend_d[0] = 32'h12345678;
    do_txn(3, 1, 0, 1'b0, 32'd0);

    // Timeout on port 0, then drain of a late response
    new_req(0);
    @(negedge clock);
    drive_reqs(); h_rdy = 1'b1; m_v = 1'b0; rsp_rdy = 2'b00;
    #1;
    chk("to_arb_latency", h_v, 0);
    @(negedge clock); #1;
    chk("to_accept_ready", req_rdy, 2'b01);
    pend_v[0] = 1'b0;
    for (int j = 0; j < TIMEOUT; j++) begin
      @(negedge clock);
      drive_reqs(); h_rdy = 1'b0; rsp_rdy = 2'b01; m_v = 1'b0; m_d = $urandom | 32'h1;
      #1;
      chk("to_pre_valid", s0_v, 0);
    end
    @(negedge clock); m_d = 32'hCAFE0001; #1;
    chk("to_rsp_valid", s0_v, 1);
    chk("to_rsp_error", s0_e, 1);
    chk("to_rsp_data_zero", s0_d, 0);
    chk("to_other_data", s1_d, 32'hCAFE0001);
    chk("to_other_valid", s1_v, 0);
    chk("to_pulse_early", tpulse, 0);
    model_last = 1'b0;
    @(negedge clock); rsp_rdy = 2'b00; new_req(1); drive_reqs(); #1;
    chk("to_pulse", tpulse, 1);
    chk("to_drain_busy", busy, 1);
    chk("to_drain_mem_ready", m_rdy, 1);
    chk("to_after_valid", s0_v, 0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clock); #1;
      chk("drain_pulse_low", tpulse, 0);
      chk("drain_busy", busy, 1);
      chk("drain_no_grant", h_v, 0);
      chk("drain_req_ready", req_rdy, 0);
    end
    @(negedge clock); m_v = 1'b1; m_d = $urandom; rsp_rdy = 2'b11; #1;
    chk("late_swallow_rsp", rsp_v, 0);
    chk("late_mem_ready", m_rdy, 1);
    do_txn(0, 1, 0, 1'b0, 32'd0);

    // Response on the timeout threshold cycle is a normal response
    new_req(0);
    do_txn(0, TIMEOUT, 0, 1'b0, 32'd0);

    // Randomized traffic
    repeat (40) begin
      refill();
      do_txn($urandom_range(0, 3), $urandom_range(0, TIMEOUT), $urandom_range(0, 2),
             1'($urandom_range(0, 1)), 32'd0);
    end

    // Reset during WAIT_RESP abandons the transaction
    pend_v[0] = 1'b0; pend_v[1] = 1'b0;
    new_req(1);
    @(negedge clock);
    drive_reqs(); h_rdy = 1'b1; m_v = 1'b0; rsp_rdy = 2'b00;
    #1;
    chk("cw_arb_latency", h_v, 0);
    @(negedge clock); #1;
    chk("cw_accept_ready", req_rdy, 2'b10);
    pend_v[1] = 1'b0;
    @(negedge clock); drive_reqs(); h_rdy = 1'b0; #1;
    chk("cw_wait_busy", busy, 1);
    @(negedge clock); clear = 1'b0;
    @(negedge clock); clear = 1'b1; m_v = 1'b1; m_d = $urandom; rsp_rdy = 2'b11; #1;
    chk("cw_req_ready", req_rdy, 0);
    chk("cw_rsp_valid", rsp_v, 0);
    chk("cw_rsp_error", rsp_e, 0);
    chk("cw_down_valid", h_v, 0);
    chk("cw_down_write", h_w, 0);
    chk("cw_mem_ready", m_rdy, 0);
    chk("cw_busy", busy, 0);
    chk("cw_timeout_pulse", tpulse, 0);
    model_last = 1'b1;
    new_req(0); new_req(1);
    do_txn(0, 0, 0, 1'b0, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
